// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl CPU-to-memory handshake controller.
// Optional abort-on-timeout behaviour is enabled with the MEM_CTRL_TIMEOUT_EN macro.
package mem_ctrl_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   // Same encoding on the CPU side (rw) and the memory side (RW).
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      WAIT,
      RELEASE,
      FINISH
   } state_t;

   function automatic logic is_read(input logic dir);
      return dir != RW_WRITE;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the asynchronous MFC handshake into the clk domain.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // NOTE: non-blocking assignments keep the two stages from collapsing into one flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: latches a CPU request and runs a full EN/MFC four-phase handshake.
// Define MEM_CTRL_TIMEOUT_EN to abort accesses that stay in WAIT for TIMEOUT cycles.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              EN,
   output logic              RW,
   output logic [ADDR_W-1:0] MAR_to_MEM,
   output logic [DATA_W-1:0] MDR_to_MEM,
   input  logic [DATA_W-1:0] MEM_to_MDR,
   input  logic              MFC
);

   state_t            state_q, state_d;
   logic              en_q, en_d;
   logic              done_q, done_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mfc_s;

   sync2 u_mfc_sync (
      .clk   (clk),
      .reset (reset),
      .d     (MFC),
      .q     (mfc_s)
   );

`ifdef MEM_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
   logic             err_q, err_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      rdata_d = rdata_q;
`ifdef MEM_CTRL_TIMEOUT_EN
      to_d    = to_q;
      cnt_d   = (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
`endif

      case (state_q)
         IDLE: begin
            if (req) begin
               mar_d   = addr;
               mdr_d   = wdata;
               rw_d    = rw;
`ifdef MEM_CTRL_TIMEOUT_EN
               to_d    = 1'b0;
`endif
               state_d = SETUP;
            end
         end
         SETUP:   state_d = WAIT;
         WAIT: begin
            if (mfc_s) begin
               if (is_read(rw_q)) rdata_d = MEM_to_MDR;
               state_d = RELEASE;
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               to_d    = 1'b1;
               state_d = RELEASE;
            end
`endif
         end
         RELEASE: if (!mfc_s) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // EN and done come straight from flops so the memory never sees a decode glitch.
      en_d   = (state_d == WAIT);
      done_d = (state_d == FINISH);
`ifdef MEM_CTRL_TIMEOUT_EN
      err_d  = done_d && to_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         rw_q    <= RW_READ;
         mar_q   <= '0;
         mdr_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         done_q  <= done_d;
         rw_q    <= rw_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_CTRL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign EN         = en_q;
   assign done       = done_q;
   assign RW         = rw_q;
   assign MAR_to_MEM = mar_q;
   assign MDR_to_MEM = mdr_q;
   assign rdata      = rdata_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural asynchronous memory answering EN with MFC.
// With MEM_CTRL_TIMEOUT_EN defined the DUT is built with TIMEOUT=8 and the abort path is exercised.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 64;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        rw = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        done, err, busy;
   logic        EN, RW;
   logic [15:0] MAR_to_MEM, MDR_to_MEM;
   logic [15:0] MEM_to_MDR = '0;
   logic        MFC = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit mute  = 1'b0;

   mem_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .rw         (rw),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .done       (done),
      .err        (err),
      .busy       (busy),
      .EN         (EN),
      .RW         (RW),
      .MAR_to_MEM (MAR_to_MEM),
      .MDR_to_MEM (MDR_to_MEM),
      .MEM_to_MDR (MEM_to_MDR),
      .MFC        (MFC)
   );

   always #5 clk = ~clk;

   // Asynchronous memory: MFC follows EN by 2 ns in both directions; mute suppresses the answer.
   logic [15:0] mem [0:255];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'h7002;
      mem[1] = 16'hF0FF;
      mem[2] = 16'h1043;
      mem[7] = 16'hC042;
      forever begin
         @(posedge EN);
         #2;
         if (!mute) begin
            if (RW == RW_READ) MEM_to_MDR = mem[MAR_to_MEM[7:0]];
            else               mem[MAR_to_MEM[7:0]] = MDR_to_MEM;
            MFC = 1'b1;
         end
         @(negedge EN);
         #2;
         MFC = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access; cycle numbers count edges after the edge that sampled req.
   task automatic run_access(input string tag, input logic rw_i, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] exp_rd,
                             input logic exp_err, input int exp_lat, input int exp_en_cyc);
      int   cyc = 0;
      int   dones = 0;
      int   en_rise = -1;
      int   en_cyc = 0;
      int   done_cyc = -1;
      logic err_seen = 1'b0;
      logic stable = 1'b1;
      req = 1'b1; rw = rw_i; addr = a; wdata = wd;
      tick();
      req = 1'b0; rw = ~rw_i; addr = ~a; wdata = ~wd;
      while (cyc < 200) begin
         if (EN) begin
            en_cyc++;
            if (en_rise < 0) en_rise = cyc;
         end
         if (busy && (RW !== rw_i || MAR_to_MEM !== a || MDR_to_MEM !== wd)) stable = 1'b0;
         if (done) begin
            dones++;
            done_cyc = cyc;
            err_seen = err;
         end
         if (!busy) break;
         tick();
         cyc++;
      end
      check({tag, ".back_to_idle"}, 32'(busy), 32'd0);
      check({tag, ".en_rise_cycle"}, 32'(en_rise), 32'd1);
      check({tag, ".en_high_cycles"}, 32'(en_cyc), 32'(exp_en_cyc));
      check({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_lat));
      check({tag, ".done_count"}, 32'(dones), 32'd1);
      check({tag, ".err"}, 32'(err_seen), 32'(exp_err));
      check({tag, ".bus_stable"}, 32'(stable), 32'd1);
      check({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
   endtask

   typedef struct {
      string       name;
      logic        rw;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int   cyc;
      int   dones;
      int   rises;
      int   first_done;
      int   second_rise;
      logic en_prev;
      logic [15:0] rd1, rd2;

      vecs[0] = '{"rd_0002",     RW_READ,  16'h0002, 16'h5A5A, 16'h1043};
      vecs[1] = '{"wr_0010",     RW_WRITE, 16'h0010, 16'hBEEF, 16'h1043};
      vecs[2] = '{"rd_0010",     RW_READ,  16'h0010, 16'hA5A5, 16'hBEEF};
      vecs[3] = '{"rd_0000",     RW_READ,  16'h0000, 16'h0000, 16'h7002};
      vecs[4] = '{"rd_0007",     RW_READ,  16'h0007, 16'hFFFF, 16'hC042};
      vecs[5] = '{"wr_0003",     RW_WRITE, 16'h0003, 16'h1234, 16'hC042};

      // Reset values while reset is held.
      repeat (3) tick();
      check("rst.EN", 32'(EN), 32'd0);
      check("rst.RW", 32'(RW), 32'd1);
      check("rst.MAR", 32'(MAR_to_MEM), 32'd0);
      check("rst.MDR", 32'(MDR_to_MEM), 32'd0);
      check("rst.rdata", 32'(rdata), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.err", 32'(err), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_access(vecs[i].name, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, 1'b0, 7, 3);
         tick();
      end

      // Back-to-back reads with req held high: second access starts only after FINISH.
      req = 1'b1; rw = RW_READ; addr = 16'h0000;
      tick();
      addr = 16'h0007;
      cyc = 0; dones = 0; rises = 0; first_done = -1; second_rise = -1;
      en_prev = 1'b0; rd1 = '0; rd2 = '0;
      while (cyc < 100) begin
         if (EN && !en_prev) begin
            rises++;
            if (rises == 2) second_rise = cyc;
         end
         en_prev = EN;
         if (done) begin
            dones++;
            if (dones == 1) begin
               first_done = cyc;
               rd1 = rdata;
            end else begin
               rd2 = rdata;
               req = 1'b0;
            end
         end
         if (dones == 2 && !busy) break;
         tick();
         cyc++;
      end
      req = 1'b0;
      check("b2b.done_count", 32'(dones), 32'd2);
      check("b2b.rdata_first", 32'(rd1), 32'h7002);
      check("b2b.rdata_second", 32'(rd2), 32'hC042);
      check("b2b.first_done_cycle", 32'(first_done), 32'd7);
      check("b2b.second_en_rise_cycle", 32'(second_rise), 32'd10);
      tick();

      // req pulsed during WAIT must neither start nor queue an access.
      req = 1'b1; rw = RW_READ; addr = 16'h0001;
      tick();
      req = 1'b0; addr = 16'h0002;
      cyc = 0; dones = 0; rises = 0; en_prev = 1'b0;
      while (cyc < 30) begin
         if (EN && !en_prev) rises++;
         en_prev = EN;
         if (done) dones++;
         req = (cyc == 2);
         tick();
         cyc++;
      end
      req = 1'b0;
      check("pulse.done_count", 32'(dones), 32'd1);
      check("pulse.en_rises", 32'(rises), 32'd1);
      check("pulse.rdata", 32'(rdata), 32'hF0FF);
      check("pulse.busy", 32'(busy), 32'd0);

      // Reset during WAIT aborts on the same edge with no done pulse.
      mute = 1'b1;
      req = 1'b1; rw = RW_READ; addr = 16'h0002;
      tick();
      req = 1'b0;
      tick();
      tick();
      check("rstmid.in_wait_EN", 32'(EN), 32'd1);
      reset = 1'b1;
      tick();
      check("rstmid.EN", 32'(EN), 32'd0);
      check("rstmid.busy", 32'(busy), 32'd0);
      check("rstmid.done", 32'(done), 32'd0);
      check("rstmid.rdata", 32'(rdata), 32'd0);
      dones = 0;
      tick();
      reset = 1'b0;
      mute = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (done) dones++;
         tick();
      end
      check("rstmid.no_done", 32'(dones), 32'd0);
      run_access("rstmid.rd_0001", RW_READ, 16'h0001, 16'h0000, 16'hF0FF, 1'b0, 7, 3);
      tick();

`ifdef MEM_CTRL_TIMEOUT_EN
      // Memory never answers: 8 WAIT cycles, one RELEASE, then done with err, rdata kept.
      mute = 1'b1;
      run_access("timeout", RW_READ, 16'h0003, 16'h0000, 16'hF0FF, 1'b1, 10, 8);
      mute = 1'b0;
      tick();
      run_access("after_timeout", RW_READ, 16'h0007, 16'h0000, 16'hC042, 1'b0, 7, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
